reg_bank8_rr: RTL
=================

// Module: reg_bank8_rr
// PURPOSE
//   Eight-channel 16-bit register bank with per-channel pending flags and a
//   round-robin drain sequencer. It sits directly upstream of the 8-way 16-bit
//   word mux: ch_bus feeds mux inputs a..h, and sel drives the mux select.
//   A snapshot of the selected word is presented on a valid/ready port.
// PARAMETERS
//   WIDTH  16  data width per channel
//   OVF_W  8   width of the saturating overwrite counter
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous, active-low reset
//   wr_en      in   1        write strobe
//   wr_addr    in   3        channel index for the write
//   wr_data    in   WIDTH    write data
//   ch_bus     out  8*WIDTH  channel i = ch_bus[WIDTH*i +: WIDTH], to mux a..h
//   sel        out  3        channel currently granted, to mux select
//   out_valid  out  1        out_data/out_chan hold a granted word
//   out_ready  in   1        consumer accepts the word
//   out_data   out  WIDTH    snapshot of the granted channel register
//   out_chan   out  3        index of the granted channel
//   pending    out  8        per-channel "written, not yet granted" flags
//   ovf_cnt    out  OVF_W    writes that hit an already-pending channel
// BEHAVIOUR
//   Reset (rst_n low, async): all channel regs 0, pending 0, sel 0, out_valid 0,
//     out_data 0, out_chan 0, ovf_cnt 0, rr_ptr 0, state IDLE.
//   Write: on an edge with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 1.
//     If pending[wr_addr] was already 1 (and is not cleared by a grant on that
//     same edge), ovf_cnt increments, saturating at all-ones. Writes are always
//     accepted, in any state.
//   FSM states: IDLE, PRESENT.
//   IDLE: if pending != 0, grant the first set bit scanning rr_ptr, rr_ptr+1, ...,
//     wrapping 7 -> 0. On that edge: sel, out_chan <= g; out_data <= reg[g]
//     (the pre-edge value); pending[g] cleared; out_valid <= 1; go to PRESENT.
//     If pending == 0, stay in IDLE with out_valid 0.
//   Grant/write collision on channel g in the same edge: out_data takes the old
//     value; the write's pending set wins, so pending[g] stays 1. No ovf increment.
//   PRESENT: out_valid, out_data, out_chan and sel are held stable.
//     out_valid stays 1 until out_ready=1 on an edge. On accept:
//     out_valid <= 0, rr_ptr <= g+1 (mod 8), go to IDLE.
//     out_ready is ignored when out_valid=0.
//   Writes to g during PRESENT update reg[g] and ch_bus but not out_data.
//   Latency: write at edge E0 -> grant at E1 -> out_valid high after E1,
//     if the FSM was IDLE. One bubble cycle follows each accept, so
//     the maximum throughput is 1 word per 2 cycles.
//   ch_bus and pending are direct register outputs, with no combinational paths
//     from inputs to outputs.
//   Reset asserted mid-PRESENT: everything clears immediately. The word is lost.
// TESTING
//   1. Reset, then write ch3=16'hBEEF; out_ready=1 -> out_valid high 1 cycle after
//      the write edge, out_chan=3, out_data=BEEF, sel=3; pending=0 after grant.
//   2. Write all 8 channels (value 16'h1000+i) over 8 cycles, out_ready=1 ->
//      grants in order 0..7, each word matching; rr_ptr wraps to 0.
//   3. Hold out_ready=0 for 5 cycles with ch5 granted, then write ch5=16'h0002
//      -> out_data stays old value, pending[5]=1; on ready, ch5 is granted again
//      with 0002.
//   4. Write ch2 three times before its grant -> ovf_cnt=2; drive 300 repeated
//      overwrites -> ovf_cnt saturates at 8'hFF.
//   5. Write ch4 on the same edge it is granted -> out_data=old, pending[4]=1,
//      ovf_cnt unchanged, ch4 regranted after the accept.
//   6. Assert rst_n low asynchronously mid-PRESENT -> out_valid, pending,
//      ch_bus and ovf_cnt go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/reg_bank8_rr_if.sv
// Write port and granted-word stream of the eight-channel register bank.
// master: producer/consumer side, slave: the bank.
interface reg_bank8_rr_if #(
    parameter int WIDTH = 16
);
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       out_chan;

    modport master (
        output wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_data, out_chan
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_data, out_chan
    );
endinterface

// File: rtl/reg_bank8_rr.sv
// Eight-channel register bank with pending flags, a saturating overwrite counter
// and a round-robin drain sequencer presenting one snapshot word at a time.
module reg_bank8_rr #(
    parameter int WIDTH = 16,
    parameter int OVF_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_bank8_rr_if.slave        bus,
    output logic [8*WIDTH-1:0]   ch_bus,
    output logic [2:0]           sel,
    output logic [7:0]           pending,
    output logic [OVF_W-1:0]     ovf_cnt
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t                 state_q, state_d;
    logic [7:0][WIDTH-1:0]  regs_q;
    logic [7:0]             pending_q, pending_d;
    logic [2:0]             rr_q;
    logic [2:0]             gnt_q;
    logic [WIDTH-1:0]       data_q;
    logic [OVF_W-1:0]       ovf_q;

    logic                   found;
    logic [2:0]             found_idx;
    logic [2:0]             scan_idx;
    logic                   do_grant;
    logic                   do_accept;
    logic                   ovf_hit;

    // First pending channel at or after rr_q, wrapping 7 -> 0.
    always_comb begin
        found     = 1'b0;
        found_idx = rr_q;
        scan_idx  = rr_q;
        for (int unsigned i = 0; i < 8; i++) begin
            scan_idx = rr_q + 3'(i);
            if (!found && pending_q[scan_idx]) begin
                found     = 1'b1;
                found_idx = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found)         state_d = PRESENT;
            PRESENT: if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // A write to the channel being granted on the same edge keeps it pending
    // and is not an overwrite, since the old value was just captured.
    always_comb begin
        do_grant  = (state_q == IDLE) && found;
        do_accept = (state_q == PRESENT) && bus.out_ready;
        pending_d = pending_q;
        if (do_grant) begin
            pending_d[found_idx] = 1'b0;
        end
        if (bus.wr_en) begin
            pending_d[bus.wr_addr] = 1'b1;
        end
        ovf_hit = bus.wr_en && pending_q[bus.wr_addr]
                  && !(do_grant && (found_idx == bus.wr_addr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            gnt_q     <= '0;
            data_q    <= '0;
            ovf_q     <= '0;
        end else begin
            if (bus.wr_en) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
            pending_q <= pending_d;
            if (ovf_hit && (ovf_q != '1)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
            if (do_grant) begin
                gnt_q  <= found_idx;
                data_q <= regs_q[found_idx];
            end
            if (do_accept) begin
                rr_q <= gnt_q + 3'd1;
            end
        end
    end

    assign ch_bus        = regs_q;
    assign sel           = gnt_q;
    assign pending       = pending_q;
    assign ovf_cnt       = ovf_q;
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.out_data  = data_q;
    assign bus.out_chan  = gnt_q;

endmodule
